dma_ctrl: RTL

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_if.sv | 44 ++++
 rtl/dma_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA copy engine: default widths and the FSM state encoding.
package dma_pkg;

   localparam int DMA_ADDR_WIDTH = 32;
   localparam int DMA_DATA_WIDTH = 32;
   localparam int DMA_LEN_WIDTH  = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      FINISH  = 3'd4
   } dma_state_t;

endpackage

// File: rtl/dma_if.sv
// Register-side controls plus the read/write memory handshakes of the DMA copy engine.
interface dma_if
   import dma_pkg::*;
#(
   parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
   parameter int DATA_WIDTH = DMA_DATA_WIDTH,
   parameter int LEN_WIDTH  = DMA_LEN_WIDTH
);

   logic                  start;
   logic                  irq_enable;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [ADDR_WIDTH-1:0] dst_addr;
   logic [LEN_WIDTH-1:0]  length;
   logic                  busy;
   logic                  done;
   logic                  irq;

   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_gnt;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;

   logic                  wr_req;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_gnt;

   modport master (
      input  start, irq_enable, src_addr, dst_addr, length,
      input  rd_gnt, rd_valid, rd_data, wr_gnt,
      output busy, done, irq,
      output rd_req, rd_addr, wr_req, wr_addr, wr_data
   );

   modport slave (
      output start, irq_enable, src_addr, dst_addr, length,
      output rd_gnt, rd_valid, rd_data, wr_gnt,
      input  busy, done, irq,
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data
   );

endinterface

// File: rtl/dma_ctrl.sv
// Single-channel memory-to-memory copy engine: one word is read, held in a single data
// register, then written, until the captured word count is exhausted.
module dma_ctrl
   import dma_pkg::*;
#(
   parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
   parameter int DATA_WIDTH = DMA_DATA_WIDTH,
   parameter int LEN_WIDTH  = DMA_LEN_WIDTH
) (
   input logic   ACLK,
   input logic   ARESET,
   dma_if.master bus
);

   localparam int BPW        = DATA_WIDTH / 8;
   localparam int WORD_SHIFT = $clog2(BPW);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BPW);

   dma_state_t            state;
   dma_state_t            next_state;
   logic [ADDR_WIDTH-1:0] src_q;
   logic [ADDR_WIDTH-1:0] dst_q;
   logic [LEN_WIDTH-1:0]  remaining_q;
   logic [LEN_WIDTH-1:0]  start_words;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  done_q;
   logic                  start_accept;
   logic                  capture_data;
   logic                  write_accept;
   logic                  rd_req_c;
   logic                  wr_req_c;

   // Trailing bytes that do not fill a whole word are dropped.
   assign start_words  = bus.length >> WORD_SHIFT;
   assign start_accept = (state == IDLE) && bus.start;
   assign write_accept = (state == WR_REQ) && bus.wr_gnt;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A read that returns data in its grant cycle skips RD_WAIT entirely.
   always_comb begin
      next_state   = state;
      capture_data = 1'b0;
      rd_req_c     = 1'b0;
      wr_req_c     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               next_state = (start_words == '0) ? FINISH : RD_REQ;
            end
         end
         RD_REQ: begin
            rd_req_c = 1'b1;
            if (bus.rd_gnt) begin
               if (bus.rd_valid) begin
                  capture_data = 1'b1;
                  next_state   = WR_REQ;
               end else begin
                  next_state = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (bus.rd_valid) begin
               capture_data = 1'b1;
               next_state   = WR_REQ;
            end
         end
         WR_REQ: begin
            wr_req_c = 1'b1;
            if (bus.wr_gnt) begin
               next_state = (remaining_q == LEN_WIDTH'(1)) ? FINISH : RD_REQ;
            end
         end
         FINISH: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Addresses advance only once the write is accepted, so both stay stable through stalls.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         src_q       <= '0;
         dst_q       <= '0;
         remaining_q <= '0;
         data_q      <= '0;
      end else begin
         if (start_accept) begin
            src_q       <= bus.src_addr;
            dst_q       <= bus.dst_addr;
            remaining_q <= start_words;
         end else if (write_accept) begin
            src_q       <= src_q + ADDR_STEP;
            dst_q       <= dst_q + ADDR_STEP;
            remaining_q <= remaining_q - LEN_WIDTH'(1);
         end
         if (capture_data) begin
            data_q <= bus.rd_data;
         end
      end
   end

   // done is cleared by an accepted start and raised on entry to FINISH, then held.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         done_q <= 1'b0;
      end else if (start_accept) begin
         done_q <= (start_words == '0);
      end else if ((next_state == FINISH) && (state != FINISH)) begin
         done_q <= 1'b1;
      end
   end

   assign bus.busy    = (state != IDLE);
   assign bus.done    = done_q;
   assign bus.irq     = (state == FINISH) && bus.irq_enable;
   assign bus.rd_req  = rd_req_c;
   assign bus.rd_addr = src_q;
   assign bus.wr_req  = wr_req_c;
   assign bus.wr_addr = dst_q;
   assign bus.wr_data = data_q;

endmodule
